// File: rtl/counter.sv
// Parameterised up-counter with count enable, terminal-count flag and wrap pulse.
// Counts modulo MAX_VALUE+1; async active-high reset clears all state.
module counter #(
    parameter int unsigned           WIDTH     = 8,
    parameter logic [WIDTH-1:0]      MAX_VALUE = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             term;

    assign term = (count_q == MAX_VALUE);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (enable) begin
            if (term) begin
                count_d = '0;
                wrap_d  = 1'b1;
            end else begin
                count_d = count_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count  = count_q;
    assign wrap   = wrap_q;
    assign at_max = term;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: default 8-bit wrap and a 4-bit mod-10 instance.
// Each comparison is an immediate assertion that counts its own failure.
module tb_counter;

    logic       clk = 1'b0;
    logic       rst, en;
    logic       rst4, en4;
    logic [7:0] cnt8;
    logic       atm8, wrp8;
    logic [3:0] cnt4;
    logic       atm4, wrp4;

    int checks = 0;
    int errors = 0;
    int wraps  = 0;

    always #5 clk = ~clk;

    counter #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .reset  (rst),
        .enable (en),
        .count  (cnt8),
        .at_max (atm8),
        .wrap   (wrp8)
    );

    counter #(.WIDTH(4), .MAX_VALUE(4'd9)) dut4 (
        .clk    (clk),
        .reset  (rst4),
        .enable (en4),
        .count  (cnt4),
        .at_max (atm4),
        .wrap   (wrp4)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        rst4 = 1'b1;
        en4  = 1'b0;
        #12;
        chk("rst_count", 32'(cnt8), 32'h0);
        chk("rst_wrap", 32'(wrp8), 32'h0);
        chk("rst_atmax", 32'(atm8), 32'h0);
        chk("rst_count4", 32'(cnt4), 32'h0);

        // basic counting
        rst = 1'b0;
        en  = 1'b1;
        step(); chk("basic1", 32'(cnt8), 32'h1);
        step(); chk("basic2", 32'(cnt8), 32'h2);
        step(); chk("basic3", 32'(cnt8), 32'h3);
        en = 1'b0;
        step(); chk("basic_hold", 32'(cnt8), 32'h3);

        // reset mid-count
        rst = 1'b1; #1; rst = 1'b0;
        en = 1'b1;
        step(); chk("mid1", 32'(cnt8), 32'h1);
        step(); chk("mid2", 32'(cnt8), 32'h2);
        rst = 1'b1; #1;
        chk("mid_rst_now", 32'(cnt8), 32'h0);
        chk("mid_rst_wrap", 32'(wrp8), 32'h0);
        step();
        chk("mid_rst_edge", 32'(cnt8), 32'h0);
        rst = 1'b0;

        // enable toggle
        en = 1'b1; step(); chk("tog1", 32'(cnt8), 32'h1);
        en = 1'b0; step(); chk("tog0", 32'(cnt8), 32'h1);
        en = 1'b1; step(); chk("tog2", 32'(cnt8), 32'h2);

        // default wrap
        for (int i = 3; i <= 255; i++) step();
        chk("ff_count", 32'(cnt8), 32'hff);
        chk("ff_atmax", 32'(atm8), 32'h1);
        chk("ff_wrap", 32'(wrp8), 32'h0);
        step();
        chk("wrap_count", 32'(cnt8), 32'h0);
        chk("wrap_pulse", 32'(wrp8), 32'h1);
        chk("wrap_atmax", 32'(atm8), 32'h0);
        step();
        chk("wrap_next", 32'(cnt8), 32'h1);
        chk("wrap_once", 32'(wrp8), 32'h0);

        // async reset between edges, held with enable
        #3;
        rst = 1'b1;
        #1;
        chk("async_now", 32'(cnt8), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("async_hold", 32'(cnt8), 32'h0);
            chk("async_wrap", 32'(wrp8), 32'h0);
        end
        rst = 1'b0;
        en  = 1'b0;
        step();
        en = 1'b1;
        step();
        chk("post_rel", 32'(cnt8), 32'h1);

        // custom terminal: mod 10
        rst4 = 1'b0;
        en4  = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk($sformatf("m10_count%0d", i), 32'(cnt4), 32'(i % 10));
            chk($sformatf("m10_wrap%0d", i), 32'(wrp4),
                (i == 10) ? 32'h1 : 32'h0);
            chk($sformatf("m10_atmax%0d", i), 32'(atm4),
                (i == 9) ? 32'h1 : 32'h0);
            if (wrp4) wraps++;
        end
        chk("m10_wrap_total", 32'(wraps), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Parameterised free-running up-counter with a count-enable input.
- Used as a generic building block for timers, address generators and event counters across the design.
- Single clock domain, asynchronous active-high reset, no handshake.

Parameters:
- WIDTH, 8, bit width of the count register and output (legal range 1..32).
- MAX_VALUE, 2**WIDTH-1, terminal value; after reaching it, the next enabled increment wraps count to 0 (legal range 1..2**WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset. Clears all state immediately on assertion. Release is sampled on clk.
- enable  input  1  count enable, sampled on rising clk edge.
- count  output  WIDTH  current count value, driven directly from a register (no combinational path from inputs).
- at_max  output  1  combinational flag, high when count == MAX_VALUE.
- wrap  output  1  registered one-cycle pulse, high in the cycle after an enabled increment from MAX_VALUE to 0.

Behaviour:
- Reset values: count = 0, wrap = 0. While reset is high, at_max = 0 unless MAX_VALUE == 0 (not a legal value).
- The reset edge does not need clk. While reset is high, count stays 0 regardless of enable or clk.
- On each rising clk edge with reset low:
  - enable = 1 and count < MAX_VALUE: count <= count + 1, wrap <= 0.
  - enable = 1 and count == MAX_VALUE: count <= 0, wrap <= 1.
  - enable = 0: count holds, wrap <= 0.
- Latency: count reflects an enabled edge immediately after that edge (one-cycle update). There is no pipeline.
- Arithmetic: unsigned, modulo MAX_VALUE+1. With the default MAX_VALUE this is natural 2**WIDTH wrap (e.g. 8'hFF -> 8'h00).
- Enable toggling: every cycle with enable = 1 advances the count by exactly 1. Cycles with enable = 0 add nothing.
- Reset mid-count: asserting reset while enable = 1 forces count = 0 and wrap = 0 immediately. The first enabled edge after release gives count = 1.
- Reset and enable together: reset wins.
- No X propagation on outputs after reset has been asserted once.

Decomposition:
- No shared package. No typedefs or constants beyond the local parameters.
- Single flat module; no sub-module. The terminal-count compare and increment live inline.

Test Plan:
- Basic counting: reset pulse, then enable = 1 for 3 edges -> count = 01, 02, 03. Drop enable for 1 edge -> count stays 03.
- Reset mid-count: enable = 1 for 2 edges -> count = 02. Assert reset -> count = 00 (checked before and after the next edge) and wrap = 0.
- Enable toggle: enable 1, 0, 1 on consecutive edges -> count = 01, 01, 02.
- Default wrap (WIDTH = 8): count to 8'hFF -> at_max = 1. Next enabled edge -> count = 00, wrap = 1 for exactly one cycle, at_max = 0.
- Custom terminal (WIDTH = 4, MAX_VALUE = 9): run 12 enabled edges from reset -> count sequence 1..9, 0, 1, 2. wrap pulses once, after the 10th edge.
- Async reset: assert reset between clock edges -> count = 0 without a clk edge. Hold reset with enable = 1 for 3 edges -> count stays 0.
